// File: rtl/mux_arb_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg_pkg
// Brief    : Shared constants and helpers for the handshaked register mux.
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_reg_pkg;

    localparam logic c_MODE_ADDR = 1'b0;
    localparam logic c_MODE_RR   = 1'b1;

    // Bits needed to index n items; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_arb_reg_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    logic            w_found;
    logic [SELW-1:0] w_grant;

    // Two passes: indices at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (SELW'(i) >= ptr)) begin
                w_found = 1'b1;
                w_grant = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (SELW'(i) < ptr)) begin
                w_found = 1'b1;
                w_grant = SELW'(i);
            end
        end
    end

    assign grant     = w_grant;
    assign grant_vld = w_found;

endmodule
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Brief    : N-input handshaked mux, addressed or round-robin, with output register.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  N     = 4,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    addr,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    input  logic               out_ready
);

    logic             w_load_en;
    logic             w_addr_vld;
    logic             w_rr_vld;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_rr_grant;
    logic [SELW-1:0]  w_grant;
    logic [WIDTH-1:0] w_sel_data;
    logic [N-1:0]     w_ready;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_src;
    logic [SELW-1:0]  r_rr_ptr;

    assign w_load_en = !r_out_valid || out_ready;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_rr_grant),
        .grant_vld (w_rr_vld)
    );

    // Matching against each legal index means an address >= N never grants.
    always_comb begin
        w_addr_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((addr == SELW'(i)) && in_valid[i]) begin
                w_addr_vld = 1'b1;
            end
        end
    end

    assign w_grant   = (mode == c_MODE_RR) ? w_rr_grant : addr;
    assign w_gnt_vld = (mode == c_MODE_RR) ? w_rr_vld   : w_addr_vld;

    always_comb begin
        w_ready    = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
                w_ready[i] = w_load_en && w_gnt_vld;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_data <= w_sel_data;
                r_out_src  <= w_grant;
                if (mode == c_MODE_RR) begin
                    r_rr_ptr <= (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Brief    : Scoreboard bench for mux_arb_reg, N=4 and N=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
    } exp_t;

    logic clk;
    logic rst;

    logic        a_mode;
    logic [1:0]  a_addr;
    logic [3:0]  a_in_valid;
    logic [63:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_src;
    logic        a_out_ready;

    logic        b_mode;
    logic [1:0]  b_addr;
    logic [2:0]  b_in_valid;
    logic [47:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_src;
    logic        b_out_ready;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp;
    int   n_err;

    mux_arb_reg #(.WIDTH(16), .N(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (a_mode),
        .addr      (a_addr),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_src   (a_out_src),
        .out_ready (a_out_ready)
    );

    mux_arb_reg #(.WIDTH(16), .N(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (b_mode),
        .addr      (b_addr),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_src   (b_out_src),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Output-side monitors: every accepted word is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected: got data %0h src %0d expected no word", a_out_data, a_out_src);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_data", 32'(a_out_data), 32'(e.data));
                chk("a_src",  32'(a_out_src),  32'(e.src));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected: got data %0h src %0d expected no word", b_out_data, b_out_src);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_data", 32'(b_out_data), 32'(e.data));
                chk("b_src",  32'(b_out_src),  32'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a_mode = 1'b0; a_addr = '0; a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b0;
        b_mode = 1'b0; b_addr = '0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data",  32'(a_out_data),  32'd0);
        chk("rst_src",   32'(a_out_src),   32'd0);
        rst = 1'b0;

        // Move the round-robin pointer off zero so the reset below has to clear it.
        a_mode = 1'b1; a_in_valid = 4'b0010; a_in_data[16 +: 16] = 16'h0BEE; a_out_ready = 1'b1;
        qa.push_back('{16'h0BEE, 2'd1});
        cyc();
        a_in_valid = '0;
        cyc();

        // Reset while a loaded word is stalled.
        a_mode = 1'b0; a_addr = 2'd2; a_in_valid = 4'b0100; a_in_data[32 +: 16] = 16'h1234; a_out_ready = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_in_ready), 32'h4);
        cyc();
        chk("midrst_loaded", 32'(a_out_data), 32'h1234);
        a_in_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_data",  32'(a_out_data),  32'd0);
        chk("midrst_src",   32'(a_out_src),   32'd0);
        #1 rst = 1'b0;
        cyc();

        // Fairness: pointer restarts at 0 after reset.
        a_mode = 1'b1; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'hB000 + 16'(i);
        for (int k = 0; k < 6; k++) qa.push_back('{16'hB000 + 16'(k % 4), 2'(k % 4)});
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_full_rate", 32'(a_out_valid), 32'd1);
        end
        a_in_valid = '0;
        cyc();

        // Skip and wrap: pointer parked at 1 via one grant of input 0.
        for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'hC000 + 16'(i);
        a_in_valid = 4'b0001;
        qa.push_back('{16'hC000, 2'd0});
        cyc();
        a_in_valid = 4'b1001;
        qa.push_back('{16'hC003, 2'd3});
        qa.push_back('{16'hC000, 2'd0});
        qa.push_back('{16'hC003, 2'd3});
        cyc(); cyc(); cyc();
        a_in_valid = '0;
        cyc();

        // Addressed select.
        a_mode = 1'b0; a_addr = 2'd3; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'hA000 + 16'(i);
        #1;
        chk("addr_ready", 32'(a_in_ready), 32'h8);
        qa.push_back('{16'hA003, 2'd3});
        cyc();
        chk("addr_data", 32'(a_out_data), 32'hA003);
        chk("addr_src",  32'(a_out_src),  32'd3);
        a_in_valid = 4'b0111;
        #1;
        chk("addr_noready", 32'(a_in_ready), 32'h0);
        cyc();
        chk("addr_fall", 32'(a_out_valid), 32'd0);

        // Backpressure, then drain and load on the same edge.
        a_addr = 2'd1; a_in_valid = 4'b0010; a_in_data[16 +: 16] = 16'hD001; a_out_ready = 1'b0;
        qa.push_back('{16'hD001, 2'd1});
        cyc();
        a_in_data[16 +: 16] = 16'hD011;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 32'(a_in_ready), 32'h0);
            chk("bp_hold",  32'(a_out_data), 32'hD001);
            cyc();
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_drain_ready", 32'(a_in_ready), 32'h2);
        qa.push_back('{16'hD011, 2'd1});
        cyc();
        chk("bp_nobubble", 32'(a_out_valid), 32'd1);
        chk("bp_newdata",  32'(a_out_data),  32'hD011);
        a_in_valid = '0;
        cyc();

        // N=3: address 3 is out of range; round-robin wraps at 2.
        b_mode = 1'b0; b_addr = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) b_in_data[i*16 +: 16] = 16'hE000 + 16'(i);
        #1;
        chk("n3_addr_ready", 32'(b_in_ready), 32'h0);
        cyc();
        chk("n3_addr_valid", 32'(b_out_valid), 32'd0);
        b_mode = 1'b1;
        for (int k = 0; k < 4; k++) qb.push_back('{16'hE000 + 16'(k % 3), 2'(k % 3)});
        cyc(); cyc(); cyc(); cyc();
        b_in_valid = '0;
        cyc();
        cyc();

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
